// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared types for the pipeline sequencing controller: FSM states and forwarding encodings.
package pipe_ctrl_pkg;

    typedef enum logic [1:0] {
        RUN      = 2'b00,
        MEM_WAIT = 2'b01,
        FAULT    = 2'b10
    } state_e;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    // EX/MEM wins over MEM/WB because it holds the younger result; x0 never forwards.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic       mem_we,
        input logic [4:0] mem_rd,
        input logic       wb_we,
        input logic [4:0] wb_rd
    );
        if (mem_we && (mem_rd != 5'd0) && (mem_rd == rs)) return FWD_MEM;
        if (wb_we && (wb_rd != 5'd0) && (wb_rd == rs))    return FWD_WB;
        return FWD_RF;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_fwd_unit.sv
// Combinational load-use detector and EX operand forwarding select generator.
module hazard_fwd_unit
    import pipe_ctrl_pkg::*;
(
    input  logic [4:0] i_id_rs1,
    input  logic [4:0] i_id_rs2,
    input  logic       i_id_uses_rs1,
    input  logic       i_id_uses_rs2,
    input  logic [4:0] i_ex_rs1,
    input  logic [4:0] i_ex_rs2,
    input  logic [4:0] i_ex_rd,
    input  logic       i_ex_mem_read,
    input  logic [4:0] i_mem_rd,
    input  logic       i_mem_reg_write,
    input  logic [4:0] i_wb_rd,
    input  logic       i_wb_reg_write,
    output logic       o_load_use,
    output logic [1:0] o_fwd_a,
    output logic [1:0] o_fwd_b
);

    logic w_rs1_hit;
    logic w_rs2_hit;

    assign w_rs1_hit  = i_id_uses_rs1 && (i_ex_rd == i_id_rs1);
    assign w_rs2_hit  = i_id_uses_rs2 && (i_ex_rd == i_id_rs2);
    assign o_load_use = i_ex_mem_read && (i_ex_rd != 5'd0) && (w_rs1_hit || w_rs2_hit);

    assign o_fwd_a = fwd_sel(i_ex_rs1, i_mem_reg_write, i_mem_rd, i_wb_reg_write, i_wb_rd);
    assign o_fwd_b = fwd_sel(i_ex_rs2, i_mem_reg_write, i_mem_rd, i_wb_reg_write, i_wb_rd);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Five-stage pipeline sequencing controller: stall/flush/freeze enables, forwarding, memory timeout.
// Optional performance counters are built when PIPE_PERF_EN is defined.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int TIMEOUT = 256,
    parameter int CNT_W   = $clog2(TIMEOUT)
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic [4:0]  ex_rs1,
    input  logic [4:0]  ex_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_MemRead,
    input  logic        ex_RegWrite,
    input  logic        ex_branch_taken,
    input  logic [4:0]  mem_rd,
    input  logic        mem_RegWrite,
    input  logic [4:0]  wb_rd,
    input  logic        wb_RegWrite,
    input  logic        dmem_req,
    input  logic        dmem_ready,
    output logic        pc_en,
    output logic        ifid_en,
    output logic        idex_en,
    output logic        exmem_en,
    output logic        memwb_en,
    output logic        ifid_flush,
    output logic        idex_flush,
    output logic [1:0]  fwd_a,
    output logic [1:0]  fwd_b,
    output logic        mem_fault,
    output logic [31:0] stall_cycles,
    output logic [31:0] flush_count,
    output logic [31:0] wait_cycles
);

    state_e           r_state, w_state_nxt;
    logic [CNT_W-1:0] r_wait_cnt, w_wait_cnt_nxt;
    logic             r_mem_fault, w_mem_fault_nxt;
    logic             w_load_use;
    logic [1:0]       w_fwd_a, w_fwd_b;
    logic             w_run_rules;
    logic             w_in_wait;
    logic             w_apply_branch;
    logic             w_apply_stall;

    hazard_fwd_unit u_hazard_fwd (
        .i_id_rs1        (id_rs1),
        .i_id_rs2        (id_rs2),
        .i_id_uses_rs1   (id_uses_rs1),
        .i_id_uses_rs2   (id_uses_rs2),
        .i_ex_rs1        (ex_rs1),
        .i_ex_rs2        (ex_rs2),
        .i_ex_rd         (ex_rd),
        .i_ex_mem_read   (ex_MemRead),
        .i_mem_rd        (mem_rd),
        .i_mem_reg_write (mem_RegWrite),
        .i_wb_rd         (wb_rd),
        .i_wb_reg_write  (wb_RegWrite),
        .o_load_use      (w_load_use),
        .o_fwd_a         (w_fwd_a),
        .o_fwd_b         (w_fwd_b)
    );

    always_comb begin
        // NOTE: every signal gets a default before the case so no path can infer a latch.
        w_state_nxt     = r_state;
        w_wait_cnt_nxt  = r_wait_cnt;
        w_mem_fault_nxt = r_mem_fault;
        w_run_rules     = 1'b0;
        w_in_wait       = 1'b0;
        case (r_state)
            RUN: begin
                if (dmem_req && !dmem_ready) begin
                    w_state_nxt    = MEM_WAIT;
                    w_wait_cnt_nxt = '0;
                end else begin
                    w_run_rules = 1'b1;
                end
            end
            MEM_WAIT: begin
                w_in_wait      = 1'b1;
                w_wait_cnt_nxt = r_wait_cnt + CNT_W'(1);
                if (dmem_ready) begin
                    w_state_nxt = RUN;
                    w_run_rules = 1'b1;
                end else if (r_wait_cnt == CNT_W'(TIMEOUT - 1)) begin
                    w_state_nxt     = FAULT;
                    w_mem_fault_nxt = 1'b1;
                end
            end
            FAULT:   w_state_nxt = FAULT;
            default: w_state_nxt = RUN;
        endcase
    end

    // Release cycle of a memory wait applies the branch/load-use rules in the same cycle.
    always_comb begin
        pc_en          = 1'b0;
        ifid_en        = 1'b0;
        idex_en        = 1'b0;
        exmem_en       = 1'b0;
        memwb_en       = 1'b0;
        ifid_flush     = 1'b0;
        idex_flush     = 1'b0;
        w_apply_branch = 1'b0;
        w_apply_stall  = 1'b0;
        if (!reset) begin
            ifid_flush = 1'b1;
            idex_flush = 1'b1;
        end else if (w_run_rules) begin
            pc_en    = 1'b1;
            ifid_en  = 1'b1;
            idex_en  = 1'b1;
            exmem_en = 1'b1;
            memwb_en = 1'b1;
            if (ex_branch_taken) begin
                ifid_flush     = 1'b1;
                idex_flush     = 1'b1;
                w_apply_branch = 1'b1;
            end else if (w_load_use) begin
                pc_en         = 1'b0;
                ifid_en       = 1'b0;
                idex_flush    = 1'b1;
                w_apply_stall = 1'b1;
            end
        end
    end

    assign fwd_a     = reset ? w_fwd_a : FWD_RF;
    assign fwd_b     = reset ? w_fwd_b : FWD_RF;
    assign mem_fault = r_mem_fault;

    // NOTE: sequential state uses non-blocking assignments so all flops see pre-edge values.
    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            r_state     <= RUN;
            r_wait_cnt  <= '0;
            r_mem_fault <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_wait_cnt  <= w_wait_cnt_nxt;
            r_mem_fault <= w_mem_fault_nxt;
        end
    end

`ifdef PIPE_PERF_EN
    logic [31:0] r_stall_cycles, r_flush_count, r_wait_cycles;
    logic        w_unused;

    always_ff @(negedge clk or negedge reset) begin
        if (!reset) begin
            r_stall_cycles <= '0;
            r_flush_count  <= '0;
            r_wait_cycles  <= '0;
        end else begin
            if (w_apply_stall)  r_stall_cycles <= r_stall_cycles + 32'd1;
            if (w_apply_branch) r_flush_count  <= r_flush_count + 32'd1;
            if (w_in_wait)      r_wait_cycles  <= r_wait_cycles + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
    assign flush_count  = r_flush_count;
    assign wait_cycles  = r_wait_cycles;
    assign w_unused     = ex_RegWrite;
`else
    logic w_unused;

    assign stall_cycles = '0;
    assign flush_count  = '0;
    assign wait_cycles  = '0;
    // A load always writes a register, so ex_RegWrite adds nothing to the hazard check.
    assign w_unused     = ^{ex_RegWrite, w_apply_stall, w_apply_branch, w_in_wait};
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: vector table plus multi-cycle wait/timeout/reset sequences.
module tb_pipeline_hazard_ctrl;
    import pipe_ctrl_pkg::*;

    localparam int TIMEOUT = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic [4:0]  id_rs1, id_rs2, ex_rs1, ex_rs2, ex_rd, mem_rd, wb_rd;
    logic        id_uses_rs1, id_uses_rs2, ex_MemRead, ex_RegWrite, ex_branch_taken;
    logic        mem_RegWrite, wb_RegWrite, dmem_req, dmem_ready;
    logic        pc_en, ifid_en, idex_en, exmem_en, memwb_en, ifid_flush, idex_flush;
    logic [1:0]  fwd_a, fwd_b;
    logic        mem_fault;
    logic [31:0] stall_cycles, flush_count, wait_cycles;

    int checks   = 0;
    int failures = 0;

    pipeline_hazard_ctrl #(.TIMEOUT(TIMEOUT)) dut (
        .clk             (clk),
        .reset           (reset),
        .id_rs1          (id_rs1),
        .id_rs2          (id_rs2),
        .id_uses_rs1     (id_uses_rs1),
        .id_uses_rs2     (id_uses_rs2),
        .ex_rs1          (ex_rs1),
        .ex_rs2          (ex_rs2),
        .ex_rd           (ex_rd),
        .ex_MemRead      (ex_MemRead),
        .ex_RegWrite     (ex_RegWrite),
        .ex_branch_taken (ex_branch_taken),
        .mem_rd          (mem_rd),
        .mem_RegWrite    (mem_RegWrite),
        .wb_rd           (wb_rd),
        .wb_RegWrite     (wb_RegWrite),
        .dmem_req        (dmem_req),
        .dmem_ready      (dmem_ready),
        .pc_en           (pc_en),
        .ifid_en         (ifid_en),
        .idex_en         (idex_en),
        .exmem_en        (exmem_en),
        .memwb_en        (memwb_en),
        .ifid_flush      (ifid_flush),
        .idex_flush      (idex_flush),
        .fwd_a           (fwd_a),
        .fwd_b           (fwd_b),
        .mem_fault       (mem_fault),
        .stall_cycles    (stall_cycles),
        .flush_count     (flush_count),
        .wait_cycles     (wait_cycles)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [4:0] id_rs1, id_rs2;
        logic       u1, u2;
        logic [4:0] ex_rs1, ex_rs2, ex_rd;
        logic       mr, br;
        logic [4:0] mem_rd;
        logic       mw;
        logic [4:0] wb_rd;
        logic       ww;
        logic [4:0] en;
        logic [1:0] fl, fa, fb;
        int         st0, fl0;
    } vec_t;

    vec_t vecs[14];

    function automatic logic [31:0] pexp(input logic [31:0] v);
`ifdef PIPE_PERF_EN
        return v;
`else
        return 32'd0 & v;
`endif
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks = checks + 1;
        if (act !== exp) begin
            failures = failures + 1;
            $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
        end
    endtask

    task automatic check_ctl(input string name, input logic [4:0] en, input logic [1:0] fl);
        check({name, "_en"}, {27'd0, pc_en, ifid_en, idex_en, exmem_en, memwb_en}, {27'd0, en});
        check({name, "_flush"}, {30'd0, ifid_flush, idex_flush}, {30'd0, fl});
    endtask

    task automatic check_cnt(input string name, input int st, input int fc, input int wc);
        check({name, "_stall_cycles"}, stall_cycles, pexp(st));
        check({name, "_flush_count"}, flush_count, pexp(fc));
        check({name, "_wait_cycles"}, wait_cycles, pexp(wc));
    endtask

    task automatic idle();
        id_rs1 = 0; id_rs2 = 0; id_uses_rs1 = 0; id_uses_rs2 = 0;
        ex_rs1 = 0; ex_rs2 = 0; ex_rd = 0; ex_MemRead = 0; ex_RegWrite = 0;
        ex_branch_taken = 0; mem_rd = 0; mem_RegWrite = 0; wb_rd = 0; wb_RegWrite = 0;
        dmem_req = 0; dmem_ready = 0;
    endtask

    task automatic apply(input vec_t v);
        idle();
        id_rs1 = v.id_rs1; id_rs2 = v.id_rs2; id_uses_rs1 = v.u1; id_uses_rs2 = v.u2;
        ex_rs1 = v.ex_rs1; ex_rs2 = v.ex_rs2; ex_rd = v.ex_rd;
        ex_MemRead = v.mr; ex_RegWrite = v.mr; ex_branch_taken = v.br;
        mem_rd = v.mem_rd; mem_RegWrite = v.mw; wb_rd = v.wb_rd; wb_RegWrite = v.ww;
    endtask

    initial begin
        //          id1 id2 u1 u2 xr1 xr2 xrd mr br  mrd mw wrd ww  en        fl     fa     fb    st fc
        vecs[0]  = '{0,  0,  0, 0, 0,  0,  0,  0, 0,  0,  0, 0,  0, 5'b11111, 2'b00, 2'b00, 2'b00, 0, 0};
        vecs[1]  = '{5,  0,  1, 0, 0,  0,  5,  1, 0,  0,  0, 0,  0, 5'b00111, 2'b01, 2'b00, 2'b00, 0, 0};
        vecs[2]  = '{3,  9,  1, 1, 0,  0,  9,  1, 0,  0,  0, 0,  0, 5'b00111, 2'b01, 2'b00, 2'b00, 1, 0};
        vecs[3]  = '{5,  0,  0, 0, 0,  0,  5,  1, 0,  0,  0, 0,  0, 5'b11111, 2'b00, 2'b00, 2'b00, 2, 0};
        vecs[4]  = '{0,  0,  1, 1, 0,  0,  0,  1, 0,  0,  0, 0,  0, 5'b11111, 2'b00, 2'b00, 2'b00, 2, 0};
        vecs[5]  = '{5,  5,  1, 1, 0,  0,  5,  0, 0,  0,  0, 0,  0, 5'b11111, 2'b00, 2'b00, 2'b00, 2, 0};
        vecs[6]  = '{0,  0,  0, 0, 7,  0,  0,  0, 0,  7,  1, 7,  1, 5'b11111, 2'b00, 2'b10, 2'b00, 2, 0};
        vecs[7]  = '{0,  0,  0, 0, 7,  0,  0,  0, 0,  0,  1, 7,  1, 5'b11111, 2'b00, 2'b01, 2'b00, 2, 0};
        vecs[8]  = '{0,  0,  0, 0, 13, 12, 0,  0, 0,  13, 1, 12, 1, 5'b11111, 2'b00, 2'b10, 2'b01, 2, 0};
        vecs[9]  = '{0,  0,  0, 0, 7,  7,  0,  0, 0,  7,  0, 7,  0, 5'b11111, 2'b00, 2'b00, 2'b00, 2, 0};
        vecs[10] = '{0,  0,  0, 0, 0,  0,  0,  0, 0,  0,  1, 0,  1, 5'b11111, 2'b00, 2'b00, 2'b00, 2, 0};
        vecs[11] = '{0,  0,  0, 0, 0,  0,  0,  0, 1,  0,  0, 0,  0, 5'b11111, 2'b11, 2'b00, 2'b00, 2, 0};
        vecs[12] = '{5,  0,  1, 0, 0,  0,  5,  1, 1,  0,  0, 0,  0, 5'b11111, 2'b11, 2'b00, 2'b00, 2, 1};
        vecs[13] = '{0,  0,  0, 0, 0,  7,  0,  0, 0,  7,  1, 7,  1, 5'b11111, 2'b00, 2'b00, 2'b10, 2, 2};

        // Reset held low with forwarding and branch stimulus present.
        reset = 1'b0;
        idle();
        @(posedge clk);
        mem_RegWrite = 1; mem_rd = 7; ex_rs1 = 7; ex_branch_taken = 1;
        #1;
        check_ctl("reset", 5'b00000, 2'b11);
        check("reset_fwd_a", {30'd0, fwd_a}, 32'd0);
        check("reset_mem_fault", {31'd0, mem_fault}, 32'd0);
        check_cnt("reset", 0, 0, 0);
        @(posedge clk);
        idle();
        #2 reset = 1'b1;

        for (int i = 0; i < 14; i++) begin
            @(posedge clk);
            apply(vecs[i]);
            #1;
            check_ctl($sformatf("vec%0d", i), vecs[i].en, vecs[i].fl);
            check($sformatf("vec%0d_fwd_a", i), {30'd0, fwd_a}, {30'd0, vecs[i].fa});
            check($sformatf("vec%0d_fwd_b", i), {30'd0, fwd_b}, {30'd0, vecs[i].fb});
            check($sformatf("vec%0d_stall_cycles", i), stall_cycles, pexp(vecs[i].st0));
            check($sformatf("vec%0d_flush_count", i), flush_count, pexp(vecs[i].fl0));
        end

        // Memory wait of three frozen cycles with a pending branch, released on the fourth.
        for (int c = 0; c < 3; c++) begin
            @(posedge clk);
            idle(); dmem_req = 1; ex_branch_taken = 1;
            #1;
            check_ctl($sformatf("wait_frozen%0d", c), 5'b00000, 2'b00);
        end
        @(posedge clk);
        dmem_ready = 1;
        #1;
        check_ctl("wait_release", 5'b11111, 2'b11);
        @(posedge clk);
        idle();
        #1;
        check_ctl("wait_back_run", 5'b11111, 2'b00);
        check_cnt("wait_done", 2, 3, 3);

        // Timeout: one RUN cycle plus TIMEOUT cycles in MEM_WAIT, then sticky FAULT.
        for (int c = 0; c < TIMEOUT + 1; c++) begin
            @(posedge clk);
            idle(); dmem_req = 1;
            #1;
            check_ctl($sformatf("tmo_wait%0d", c), 5'b00000, 2'b00);
            check($sformatf("tmo_nofault%0d", c), {31'd0, mem_fault}, 32'd0);
        end
        @(posedge clk);
        idle(); dmem_req = 1;
        #1;
        check("tmo_fault_set", {31'd0, mem_fault}, 32'd1);
        check_ctl("tmo_fault", 5'b00000, 2'b00);
        @(posedge clk);
        idle(); dmem_ready = 1; ex_branch_taken = 1;
        mem_RegWrite = 1; mem_rd = 7; ex_rs1 = 7;
        #1;
        check_ctl("fault_sticky", 5'b00000, 2'b00);
        check("fault_sticky_flag", {31'd0, mem_fault}, 32'd1);
        check("fault_fwd_a", {30'd0, fwd_a}, {30'd0, FWD_MEM});
        check_cnt("fault", 2, 3, 7);
        #1 reset = 1'b0;
        #1;
        check("fault_reset_flag", {31'd0, mem_fault}, 32'd0);
        check_ctl("fault_reset", 5'b00000, 2'b11);
        check("fault_reset_fwd_a", {30'd0, fwd_a}, 32'd0);
        check_cnt("fault_reset", 0, 0, 0);
        #1 reset = 1'b1;
        @(posedge clk);
        idle(); mem_RegWrite = 1; mem_rd = 7; ex_rs1 = 7;
        #1;
        check_ctl("after_fault_run", 5'b11111, 2'b00);
        check("after_fault_fwd_a", {30'd0, fwd_a}, {30'd0, FWD_MEM});

        // Asynchronous reset in the middle of a memory wait.
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            idle(); dmem_req = 1;
            #1;
            check_ctl($sformatf("midwait%0d", c), 5'b00000, 2'b00);
        end
        #1 reset = 1'b0;
        #1;
        check_ctl("midwait_reset", 5'b00000, 2'b11);
        check("midwait_reset_flag", {31'd0, mem_fault}, 32'd0);
        check_cnt("midwait_reset", 0, 0, 0);
        @(posedge clk);
        idle();
        #2 reset = 1'b1;
        #1;
        check_ctl("midwait_after", 5'b11111, 2'b00);
        @(posedge clk);
        idle(); dmem_req = 1; dmem_ready = 1;
        #1;
        check_ctl("ready_same_cycle", 5'b11111, 2'b00);
        check_cnt("final", 0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central sequencing controller for the five-stage RV32I pipeline. It drives the enable and flush inputs of the PC and of the IF/ID, ID/EX, EX/MEM and MEM/WB registers. It detects load-use hazards, kills wrong-path instructions on a taken branch, freezes the whole pipe while data memory is not ready, and produces the EX-stage operand forwarding selects. It sits beside the pipeline registers and observes their rd, rs and control fields.

## Interface
Parameters:
- TIMEOUT, default 256: maximum number of MEM_WAIT cycles before a fault is declared; legal range 2..65535.
- CNT_W, default $clog2(TIMEOUT): width of the wait counter.

Ports:
- clk  in  1  pipeline clock; state updates on the negedge, matching the pipeline registers.
- reset  in  1  asynchronous, active-low reset.
- id_rs1, id_rs2  in  5 each  source registers of the instruction in ID.
- id_uses_rs1, id_uses_rs2  in  1 each  the ID instruction reads that source.
- ex_rs1, ex_rs2, ex_rd  in  5 each  register fields of the instruction in EX.
- ex_MemRead, ex_RegWrite  in  1 each  control bits of the EX instruction.
- ex_branch_taken  in  1  branch or jump resolved taken in EX.
- mem_rd  in  5; mem_RegWrite  in  1  EX/MEM destination register and write flag.
- wb_rd  in  5; wb_RegWrite  in  1  MEM/WB destination register and write flag.
- dmem_req  in  1  the MEM stage is issuing a data access.
- dmem_ready  in  1  data memory has completed the access this cycle.
- pc_en, ifid_en, idex_en, exmem_en, memwb_en  out  1 each  stage register load enables.
- ifid_flush, idex_flush  out  1 each  clear the stage register on the next edge (bubble).
- fwd_a, fwd_b  out  2 each  EX operand select: 00 regfile, 01 MEM/WB, 10 EX/MEM.
- mem_fault  out  1  sticky; data memory timed out.
- stall_cycles, flush_count, wait_cycles  out  32 each  performance counters.

## Operation
- FSM states: RUN, MEM_WAIT, FAULT. Reset state is RUN, with wait_cnt=0 and mem_fault=0.
- While reset is low:
  - all enables are 0;
  - ifid_flush and idex_flush are 1;
  - fwd_a and fwd_b are 00;
  - all counters are 0.
- Priority within RUN, highest first:
  1. Memory wait: dmem_req=1 and dmem_ready=0.
     - All five enables are 0, no flush.
     - Next state is MEM_WAIT; wait_cnt is cleared to 0.
  2. Branch: ex_branch_taken=1.
     - All enables are 1; ifid_flush and idex_flush are 1 for this cycle only.
     - State stays RUN.
  3. Load-use hazard: ex_MemRead=1, ex_rd≠0, and ex_rd matches id_rs1 (with id_uses_rs1) or id_rs2 (with id_uses_rs2).
     - pc_en=0, ifid_en=0, idex_flush=1; other enables are 1.
     - Exactly one bubble is inserted.
  4. Otherwise all enables are 1 and both flushes are 0.
- MEM_WAIT:
  - All enables are 0 and wait_cnt increments every cycle.
  - If dmem_ready=1: enables follow the RUN priority rules (2–4) in the same cycle, and the next state is RUN.
  - If wait_cnt reaches TIMEOUT-1 with dmem_ready still 0: the next state is FAULT and mem_fault is set.
- FAULT: all enables are 0 and flushes are 0. The only exit is reset.
- Forwarding (purely combinational; computed in every state), shown for fwd_a; fwd_b is identical using ex_rs2:
  - 10 if mem_RegWrite=1, mem_rd≠0 and mem_rd==ex_rs1;
  - else 01 if wb_RegWrite=1, wb_rd≠0 and wb_rd==ex_rs1;
  - else 00.
  - EX/MEM has priority over MEM/WB when both match.
- Register x0 never triggers a hazard or a forward.

## Timing
- Enables, flushes and forwarding selects are combinational from the inputs and the current state; there is zero-cycle latency from detection to control.
- State, wait_cnt, mem_fault and the counters update on the clk negedge.
- A load-use hazard costs 1 cycle and a taken branch costs 2 bubbles.
- A memory wait costs one frozen cycle per cycle with dmem_ready low.
- Simultaneous events:
  - Memory wait together with a branch: the wait wins, and the branch flush is applied on the release cycle.
  - Branch together with load-use: the flush wins and no stall is applied; the hazarding ID instruction is killed.
- An asynchronous reset assertion at any point forces the reset values immediately, including in MEM_WAIT and FAULT.

## Configuration
- PIPE_PERF_EN defined:
  - stall_cycles increments on every load-use stall cycle;
  - flush_count increments once per taken-branch flush;
  - wait_cycles increments on every cycle in MEM_WAIT.
  - All three are 32 bits and wrap modulo 2^32.
- PIPE_PERF_EN undefined: the counter logic is removed and the three ports are tied to 0.

## Structure
- Package pipe_ctrl_pkg holds:
  - the state enum (RUN, MEM_WAIT, FAULT);
  - the FWD_RF, FWD_WB and FWD_MEM encodings (00, 01, 10).
- One combinational sub-module, hazard_fwd_unit, computes the load-use detect signal, fwd_a and fwd_b. The top level holds the FSM, the wait counter and the performance counters.

## Test plan
- ex_MemRead=1, ex_rd=5, id_rs1=5, id_uses_rs1=1 -> for one cycle pc_en=0, ifid_en=0, idex_flush=1. stall_cycles goes 0→1 with PIPE_PERF_EN defined.
- mem_RegWrite=1, mem_rd=7, wb_RegWrite=1, wb_rd=7, ex_rs1=7 -> fwd_a=10. Changing mem_rd to 0 -> fwd_a=01.
- dmem_req=1, dmem_ready=0 for 3 cycles, then 1 -> all enables 0 for 3 cycles, enables 1 on the 4th cycle, state returns to RUN, wait_cycles=3.
- TIMEOUT=4, dmem_ready held at 0 -> mem_fault=1 after 4 wait cycles; enables stay 0 until reset goes low.
- ex_branch_taken=1 together with a load-use match -> ifid_flush=1, idex_flush=1, pc_en=1, no stall; flush_count=1.
- Assert reset low mid-MEM_WAIT -> state RUN, mem_fault=0, counters 0, flushes 1 while reset is low.
